// File: rtl/bus_map_pkg.sv
// Address map and default sizing for the factorial system master bus.
// Holds the memory and factorial-core windows shared by the decoder and its users.
package bus_map_pkg;

    localparam int unsigned NS_DEF = 2;
    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned CW_DEF = 8;

    localparam logic [AW_DEF-1:0] MEM_BASE = 16'h0000;
    localparam logic [AW_DEF-1:0] MEM_MASK = 16'hF800;
    localparam logic [AW_DEF-1:0] FAC_BASE = 16'h7000;
    localparam logic [AW_DEF-1:0] FAC_MASK = 16'hFE00;

    localparam logic [NS_DEF*AW_DEF-1:0] BASE_DEF = {FAC_BASE, MEM_BASE};
    localparam logic [NS_DEF*AW_DEF-1:0] MASK_DEF = {FAC_MASK, MEM_MASK};

    localparam logic [DW_DEF-1:0] ERR_DATA_DEF = 32'h0000_0000;

endpackage

// File: rtl/bus_addr_match.sv
// Single-window address comparator: hit when the masked address equals the masked base.
module bus_addr_match
    import bus_map_pkg::*;
#(
    parameter int unsigned    AW   = AW_DEF,
    parameter logic [AW-1:0]  BASE = '0,
    parameter logic [AW-1:0]  MASK = '0
) (
    input  logic [AW-1:0] addr_i,
    output logic          hit_c_o
);

    localparam logic [AW-1:0] BASE_M = BASE & MASK;

    assign hit_c_o = ((addr_i & MASK) == BASE_M);

endmodule

// File: rtl/bus_decoder_n.sv
// N-slave master bus decoder: priority one-hot select, 1-cycle read return mux,
// and unmapped-access tracking (pulse, saturating count, first-fault address).
module bus_decoder_n
    import bus_map_pkg::*;
#(
    parameter int unsigned        NS       = NS_DEF,
    parameter int unsigned        AW       = AW_DEF,
    parameter int unsigned        DW       = DW_DEF,
    parameter int unsigned        CW       = CW_DEF,
    parameter logic [NS*AW-1:0]   BASE     = BASE_DEF,
    parameter logic [NS*AW-1:0]   MASK     = MASK_DEF,
    parameter logic [DW-1:0]      ERR_DATA = ERR_DATA_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 m_req,
    input  logic                 m_wr,
    input  logic [AW-1:0]        m_addr,
    output logic [NS-1:0]        s_sel,
    input  logic [NS*DW-1:0]     s_rdata,
    output logic [DW-1:0]        m_rdata,
    output logic                 m_rvalid,
    output logic                 dec_err,
    output logic [CW-1:0]        err_cnt,
    output logic [AW-1:0]        err_addr,
    output logic                 err_vld,
    input  logic                 err_clr
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [NS-1:0] hit_c;
    logic [NS-1:0] pri_c;
    logic          found_c;
    logic          miss_c;
    logic          rd_c;

    logic [NS-1:0] rd_sel_q, rd_sel_d;
    logic          rd_err_q, rd_err_d;
    logic          rvalid_q, rvalid_d;
    logic          dec_err_q, dec_err_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic          err_vld_q, err_vld_d;
    logic [DW-1:0] rdata_c;

    for (genvar g = 0; g < int'(NS); g++) begin : g_match
        bus_addr_match #(
            .AW   (AW),
            .BASE (BASE[g*AW +: AW]),
            .MASK (MASK[g*AW +: AW])
        ) u_match (
            .addr_i  (m_addr),
            .hit_c_o (hit_c[g])
        );
    end

    // Lowest matching index wins so overlapping windows still give a one-hot select.
    always_comb begin
        pri_c   = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (hit_c[i] && !found_c) begin
                pri_c[i] = 1'b1;
                found_c  = 1'b1;
            end
        end
    end

    assign s_sel  = m_req ? pri_c : '0;
    assign miss_c = m_req && !found_c;
    assign rd_c   = m_req && !m_wr;

    // Next-state for the read return path and the error tracker.
    always_comb begin
        rd_sel_d   = '0;
        rd_err_d   = 1'b0;
        rvalid_d   = 1'b0;
        dec_err_d  = miss_c;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        err_vld_d  = err_vld_q;

        if (rd_c) begin
            rd_sel_d = s_sel;
            rd_err_d = !found_c;
            rvalid_d = 1'b1;
        end

        if (miss_c) begin
            if (err_clr) begin
                err_cnt_d = CW'(1);
            end else if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + CW'(1);
            end
            // A clear in the same cycle invalidates the old capture, so the new miss takes it.
            if (err_clr || !err_vld_q) begin
                err_addr_d = m_addr;
                err_vld_d  = 1'b1;
            end
        end else if (err_clr) begin
            err_cnt_d  = '0;
            err_addr_d = '0;
            err_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel_q   <= '0;
            rd_err_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            dec_err_q  <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_vld_q  <= 1'b0;
        end else begin
            rd_sel_q   <= rd_sel_d;
            rd_err_q   <= rd_err_d;
            rvalid_q   <= rvalid_d;
            dec_err_q  <= dec_err_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            err_vld_q  <= err_vld_d;
        end
    end

    // Return mux: one-hot OR of slave slots, forced to ERR_DATA on a miss and 0 when idle.
    always_comb begin
        rdata_c = '0;
        if (rvalid_q) begin
            if (rd_err_q) begin
                rdata_c = ERR_DATA;
            end else begin
                for (int unsigned i = 0; i < NS; i++) begin
                    if (rd_sel_q[i]) begin
                        rdata_c = rdata_c | s_rdata[i*DW +: DW];
                    end
                end
            end
        end
    end

    assign m_rdata  = rdata_c;
    assign m_rvalid = rvalid_q;
    assign dec_err  = dec_err_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
    assign err_vld  = err_vld_q;

endmodule

// File: tb/tb_bus_decoder_n.sv
// Bench for bus_decoder_n: default map (CW=8), a CW=2 copy for saturation, and an NS=4
// overlapping-window copy, all driven from one stimulus stream.
module tb_bus_decoder_n;

    localparam logic [31:0] SLOT0 = 32'hAAAA_0000;
    localparam logic [31:0] SLOT1 = 32'h0000_BBBB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m_req = 1'b0;
    logic        m_wr = 1'b0;
    logic [15:0] m_addr = 16'h0;
    logic        err_clr = 1'b0;
    logic [63:0]  s_rdata2 = 64'h0;
    logic [127:0] s_rdata4 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

    logic [1:0]  s_sel0, s_sel1;
    logic [3:0]  s_sel2;
    logic [31:0] m_rdata0, m_rdata1, m_rdata2;
    logic        m_rvalid0, m_rvalid1, m_rvalid2;
    logic        dec_err0, dec_err1, dec_err2;
    logic [7:0]  err_cnt0, err_cnt2;
    logic [1:0]  err_cnt1;
    logic [15:0] err_addr0, err_addr1, err_addr2;
    logic        err_vld0, err_vld1, err_vld2;

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] rd_q[$];
    int          m_cnt8, m_cnt2;
    logic [15:0] m_eaddr;
    logic        m_vld;

    always #5 clk = ~clk;

    initial begin
        s_rdata2 = {SLOT1, SLOT0};
    end

    bus_decoder_n u_dut0 (
        .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
        .s_sel(s_sel0), .s_rdata(s_rdata2), .m_rdata(m_rdata0), .m_rvalid(m_rvalid0),
        .dec_err(dec_err0), .err_cnt(err_cnt0), .err_addr(err_addr0), .err_vld(err_vld0),
        .err_clr(err_clr)
    );

    bus_decoder_n #(.CW(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
        .s_sel(s_sel1), .s_rdata(s_rdata2), .m_rdata(m_rdata1), .m_rvalid(m_rvalid1),
        .dec_err(dec_err1), .err_cnt(err_cnt1), .err_addr(err_addr1), .err_vld(err_vld1),
        .err_clr(err_clr)
    );

    bus_decoder_n #(
        .NS   (4),
        .BASE ({16'h0000, 16'h2000, 16'h1000, 16'h1000}),
        .MASK ({16'h0000, 16'hF000, 16'hFF00, 16'hF000})
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
        .s_sel(s_sel2), .s_rdata(s_rdata4), .m_rdata(m_rdata2), .m_rvalid(m_rvalid2),
        .dec_err(dec_err2), .err_cnt(err_cnt2), .err_addr(err_addr2), .err_vld(err_vld2),
        .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_sel(input logic [15:0] a);
        if ((a & 16'hF800) == 16'h0000) return 2'b01;
        if ((a & 16'hFE00) == 16'h7000) return 2'b10;
        return 2'b00;
    endfunction

    // Windows: 0 = 0x1xxx, 1 = 0x10xx (shadowed by 0), 2 = 0x2xxx, 3 = everything.
    function automatic logic [3:0] ref_sel4(input logic [15:0] a);
        if (a[15:12] == 4'h1) return 4'b0001;
        if (a[15:12] == 4'h2) return 4'b0100;
        return 4'b1000;
    endfunction

    task automatic model_reset();
        m_cnt8  = 0;
        m_cnt2  = 0;
        m_eaddr = 16'h0;
        m_vld   = 1'b0;
        rd_q.delete();
    endtask

    // One bus beat: drive, check the combinational select, update the model, clock, check.
    task automatic step(input logic req, input logic wr, input logic [15:0] addr, input logic clr);
        logic [1:0] esel;
        logic       miss;
        logic       rd;
        m_req   = req;
        m_wr    = wr;
        m_addr  = addr;
        err_clr = clr;
        #1;
        esel = req ? ref_sel(addr) : 2'b00;
        chk("s_sel", 64'(s_sel0), 64'(esel));
        chk("s_sel4", 64'(s_sel2), 64'(req ? ref_sel4(addr) : 4'b0000));
        miss = req && (esel == 2'b00);
        rd   = req && !wr;
        if (rd) rd_q.push_back(esel == 2'b01 ? SLOT0 : (esel == 2'b10 ? SLOT1 : 32'h0));
        if (miss) begin
            m_cnt8 = clr ? 1 : (m_cnt8 == 255 ? 255 : m_cnt8 + 1);
            m_cnt2 = clr ? 1 : (m_cnt2 == 3 ? 3 : m_cnt2 + 1);
            if (clr || !m_vld) begin
                m_eaddr = addr;
                m_vld   = 1'b1;
            end
        end else if (clr) begin
            m_cnt8  = 0;
            m_cnt2  = 0;
            m_eaddr = 16'h0;
            m_vld   = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rvalid", 64'(m_rvalid0), 64'(rd));
        chk("dec_err", 64'(dec_err0), 64'(miss));
        chk("err_cnt8", 64'(err_cnt0), 64'(m_cnt8));
        chk("err_cnt2", 64'(err_cnt1), 64'(m_cnt2));
        chk("err_addr", 64'(err_addr0), 64'(m_eaddr));
        chk("err_addr2", 64'(err_addr1), 64'(m_eaddr));
        chk("err_vld", 64'(err_vld0), 64'(m_vld));
        if (m_rvalid0) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 64'(m_rvalid0), 64'd0);
            else chk("rdata", 64'(m_rdata0), 64'(rd_q.pop_front()));
        end else begin
            chk("rdata_idle", 64'(m_rdata0), 64'd0);
        end
        err_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #3;
        chk("rst_rvalid", 64'(m_rvalid0), 64'd0);
        chk("rst_dec_err", 64'(dec_err0), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt0), 64'd0);
        chk("rst_err_addr", 64'(err_addr0), 64'd0);
        chk("rst_err_vld", 64'(err_vld0), 64'd0);
        chk("rst_rdata", 64'(m_rdata0), 64'd0);
        #20;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Decode with default windows, including the first unmapped address.
        step(1'b1, 1'b1, 16'h07FF, 1'b0);
        step(1'b1, 1'b1, 16'h7000, 1'b0);
        step(1'b1, 1'b1, 16'h71FF, 1'b0);
        step(1'b1, 1'b1, 16'h7200, 1'b0);
        step(1'b0, 1'b1, 16'h9999, 1'b0);

        // Back-to-back reads to alternating slaves, then an unmapped read.
        step(1'b1, 1'b0, 16'h0004, 1'b0);
        step(1'b1, 1'b0, 16'h7002, 1'b0);
        step(1'b1, 1'b0, 16'h0800, 1'b0);
        step(1'b1, 1'b0, 16'h0010, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h8000, 1'b0);
        step(1'b0, 1'b0, 16'h8000, 1'b0);

        // Clear alone, then first-fault capture and saturation of the 2-bit counter.
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b1, 16'h9000, 1'b0);
        step(1'b1, 1'b1, 16'hA000, 1'b0);
        step(1'b1, 1'b0, 16'hB000, 1'b0);
        step(1'b1, 1'b1, 16'hC000, 1'b0);
        step(1'b1, 1'b1, 16'h0100, 1'b0);

        // Clear colliding with a miss: the miss takes the freshly cleared state.
        step(1'b1, 1'b1, 16'hD000, 1'b1);
        step(1'b1, 1'b1, 16'hE000, 1'b0);

        // Overlapping windows on the NS=4 copy (dut0 sees these as misses).
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        step(1'b1, 1'b1, 16'h10FF, 1'b0);
        step(1'b1, 1'b1, 16'h2ABC, 1'b0);
        step(1'b1, 1'b1, 16'h5000, 1'b0);

        // Async reset right after a read is accepted: outputs drop with no clock edge.
        m_req  = 1'b1;
        m_wr   = 1'b0;
        m_addr = 16'h0004;
        @(posedge clk);
        #2;
        chk("pre_rst_rvalid", 64'(m_rvalid0), 64'd1);
        chk("pre_rst_vld", 64'(err_vld0), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_rvalid", 64'(m_rvalid0), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt0), 64'd0);
        chk("arst_err_vld", 64'(err_vld0), 64'd0);
        chk("arst_err_addr", 64'(err_addr0), 64'd0);
        chk("arst_dec_err", 64'(dec_err0), 64'd0);
        chk("arst_rdata", 64'(m_rdata0), 64'd0);
        model_reset();
        m_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 16'h7100, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);

        chk("rd_q_left", 64'(rd_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_decoder_n.md
Name: bus_decoder_n

Overview:
- Parametrised N-slave address decoder for the shared master bus of the factorial computation system.
- Per-slave base/mask match drives one-hot slave selects.
- Registers the read target so slave read data is steered back to the master one cycle later.
- Detects unmapped accesses and records them (pulse, saturating count, first-fault address).

Parameters:
- NS, 2: number of slave channels.
- AW, 16: address width.
- DW, 32: data width.
- CW, 8: error counter width.
- BASE, {16'h7000,16'h0000}: packed NS*AW base addresses; slot i at bits [i*AW +: AW].
- MASK, {16'hFE00,16'hF800}: packed NS*AW compare masks; slot 0 = memory 0x0000-0x07FF, slot 1 = factorial core 0x7000-0x71FF.
- ERR_DATA, 0: read data returned for unmapped reads.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- m_req  input  1  master request strobe, one beat per cycle.
- m_wr  input  1  1 = write, 0 = read; qualified by m_req.
- m_addr  input  AW  master address.
- s_sel  output  NS  one-hot slave select, combinational.
- s_rdata  input  NS*DW  packed slave read data, valid one cycle after the read request.
- m_rdata  output  DW  read data to master.
- m_rvalid  output  1  read data valid.
- dec_err  output  1  one-cycle pulse, unmapped access.
- err_cnt  output  CW  saturating count of unmapped accesses.
- err_addr  output  AW  address of the first unmapped access since the last clear.
- err_vld  output  1  err_addr holds a captured address.
- err_clr  input  1  synchronous clear of err_cnt, err_addr and err_vld.

Behaviour:
- Clocking and reset: one clock, clk. Asynchronous active-low reset on reset_n.
- Reset values: rd_sel_q=0, rd_err_q=0, m_rvalid=0, dec_err=0, err_cnt=0, err_addr=0, err_vld=0.
- Match rule: hit[i] = ((m_addr & MASK[i]) == (BASE[i] & MASK[i])).
- Select: s_sel is combinational and gated by m_req.
  - With overlapping windows, the lowest index wins, so s_sel is always one-hot or zero.
  - s_sel = 0 when m_req = 0.
- Read path, 1-cycle latency:
  - On a clk edge with m_req & ~m_wr: rd_sel_q <= s_sel, rd_err_q <= (s_sel==0), m_rvalid <= 1.
  - Otherwise rd_sel_q <= 0, rd_err_q <= 0, m_rvalid <= 0.
- Read data mux, combinational from the registers:
  - m_rdata = s_rdata slot selected by rd_sel_q.
  - If rd_err_q: m_rdata = ERR_DATA.
  - If m_rvalid = 0: m_rdata = 0.
- Back-to-back reads: a read every cycle to alternating slaves returns one datum per cycle, in order, with no bubbles.
- Writes: s_sel only. No m_rvalid, no read-path state change.
- Error detect: miss = m_req & (s_sel==0), for reads and writes alike.
  - dec_err <= miss, a registered one-cycle pulse the cycle after the access.
  - err_cnt increments on miss and saturates at 2^CW-1 (no wrap).
  - If miss & ~err_vld: err_addr <= m_addr, err_vld <= 1.
  - Later misses do not overwrite err_addr (first-fault capture).
- err_clr alone: err_cnt=0, err_vld=0, err_addr=0 at the next edge.
- err_clr together with a miss in the same cycle: the miss wins over the stale state.
  - err_cnt=1, err_addr=m_addr, err_vld=1.
  - dec_err still pulses.
- Reset mid-operation: pending read data is dropped (m_rvalid=0). No partial state survives.
- m_req=0 cycles: no state change except rd_sel_q, rd_err_q and m_rvalid returning to 0.

Decomposition:
- Package bus_map_pkg holds:
  - default slave count;
  - AW and DW;
  - base/mask constants for the memory and factorial core windows;
  - ERR_DATA.
- Sub-module bus_addr_match: single-slot comparator.
  - Params AW, BASE, MASK.
  - Ports addr in, hit out.
  - Instantiated NS times in a generate loop. Priority one-hot and sequential logic stay in bus_decoder_n.

Test Plan:
1. Decode, defaults: m_req=1, m_wr=1; m_addr=0x07FF -> s_sel=01; 0x7000 -> s_sel=10; 0x71FF -> 10; 0x7200 -> 00 with dec_err=1 next cycle, err_cnt=1, err_addr=0x7200, err_vld=1.
2. Read pipeline: reads to 0x0004 then 0x7002 in consecutive cycles; s_rdata slot0=0xAAAA0000, slot1=0x0000BBBB -> m_rvalid=1 for 2 cycles, m_rdata=0xAAAA0000 then 0x0000BBBB.
3. Unmapped read: read 0x8000 -> next cycle m_rvalid=1, m_rdata=ERR_DATA(0), dec_err=1.
4. First-fault capture and saturation (CW=2): misses at 0x9000, 0xA000, 0xB000, 0xC000 -> err_addr=0x9000, err_cnt 1,2,3,3.
5. Clear collision: err_cnt=3; err_clr=1 with miss at 0xD000 in the same cycle -> err_cnt=1, err_addr=0xD000, err_vld=1.
6. Async reset: assert reset_n=0 mid-cycle right after a read request -> m_rvalid, err_cnt and err_vld go 0 immediately, without a clk edge. Also check NS=4 with overlapping windows -> lowest index selected.
